// File: rtl/mem_target.sv
// mem_target: load/store responder with byte-laned word array, fault checks and wait states.
// Latency: done WAIT_CYCLES+1 cycles after acceptance; faulting requests complete the next cycle.
// Backpressure: initiator holds available until done; a still-asserted request is not re-serviced until it drops.
// Optional feature: `MEM_TARGET_WRITE_PROTECT_EN` makes stores to word index < RO_WORDS fault.
module mem_target #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int RO_WORDS    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        available,
    input  logic        is_write,
    input  logic        is_unsigned,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        op_fault,
    output logic        addr_fault,
    output logic        access_fault
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t state_q, state_d;
    logic [3:0]           cnt_q;
    logic                 req_write, req_unsigned;
    logic [1:0]           req_op, req_lane;
    logic [ADDR_BITS-1:0] req_idx;
    logic [31:0]          req_data;
    logic [31:0]          mem [0:(1<<ADDR_BITS)-1];

    logic        op_f, addr_f, range_f, wp_f, any_f;
    logic        accept, do_access;
    logic [3:0]  be;
    logic [31:0] wdata, rword, load_data;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

`ifdef MEM_TARGET_WRITE_PROTECT_EN
    assign wp_f = is_write && ((addr >> 2) < 32'(RO_WORDS));
`else
    logic unused_ro;
    assign unused_ro = ((addr >> 2) < 32'(RO_WORDS));
    assign wp_f      = 1'b0;
`endif

    // Request checks on the live inputs; all applicable flags raise together.
    always_comb begin
        op_f    = (op == 2'b11);
        addr_f  = !op_f && ((op == 2'b01 && addr[0]) || (op == 2'b10 && addr[1:0] != 2'b00));
        range_f = (addr >> (ADDR_BITS + 2)) != 32'd0;
        any_f   = op_f | addr_f | range_f | wp_f;
    end

    // Next-state logic and the two qualifying strobes.
    always_comb begin
        state_d   = state_q;
        accept    = (state_q == S_IDLE) && available;
        do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
        case (state_q)
            S_IDLE:  if (available) state_d = any_f ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  state_d = S_HOLD;
            S_HOLD:  if (!available) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    assign busy = (state_q == S_WAIT);
    assign done = (state_q == S_RESP);

    // Store lane enables and lane-replicated data from the latched request.
    always_comb begin
        be    = 4'b1111;
        wdata = req_data;
        case (req_op)
            2'b00: begin
                be    = 4'b0001 << req_lane;
                wdata = {4{req_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {req_lane[1], 1'b0};
                wdata = {2{req_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and sign/zero extension.
    always_comb begin
        rword = mem[req_idx];
        case (req_lane)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = req_lane[1] ? rword[31:16] : rword[15:0];
        case (req_op)
            2'b00:   load_data = req_unsigned ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   load_data = req_unsigned ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: load_data = rword;
        endcase
    end

    // Request latch, wait counter, fault flags and load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= 4'd0;
            req_write    <= 1'b0;
            req_unsigned <= 1'b0;
            req_op       <= 2'b00;
            req_lane     <= 2'b00;
            req_idx      <= '0;
            req_data     <= 32'd0;
            out          <= 32'd0;
            op_fault     <= 1'b0;
            addr_fault   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q        <= 4'(WAIT_CYCLES);
                req_write    <= is_write;
                req_unsigned <= is_unsigned;
                req_op       <= op;
                req_lane     <= addr[1:0];
                req_idx      <= addr[ADDR_BITS+1:2];
                req_data     <= in;
                out          <= 32'd0;
                op_fault     <= op_f;
                addr_fault   <= addr_f;
                access_fault <= any_f;
            end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (do_access && !req_write) out <= load_data;
        end
    end

    // Byte-laned array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_access && req_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[req_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_target.sv
// Bench for mem_target: byte-addressed reference memory, cycle-accurate timing expectations from
// the acceptance edge, one per-cycle compare process, plus literal pins on the model.
module tb_mem_target;
    localparam int AB = 10, WC = 2, RO = 256, DEPTH = 1 << AB;

    logic        clk = 1'b0;
    logic        reset, available, is_write, is_unsigned;
    logic [1:0]  op;
    logic [31:0] addr, in_d, out_d;
    logic        busy, done, op_fault, addr_fault, access_fault;

    mem_target #(.ADDR_BITS(AB), .WAIT_CYCLES(WC), .RO_WORDS(RO)) dut (
        .clk(clk), .reset(reset), .available(available), .is_write(is_write),
        .is_unsigned(is_unsigned), .op(op), .addr(addr), .in(in_d), .out(out_d),
        .busy(busy), .done(done), .op_fault(op_fault), .addr_fault(addr_fault),
        .access_fault(access_fault)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = -1000, done_at = -1000;
    bit exp_fault, exp_op_f, exp_addr_f, exp_acc_f, exp_chk_out;
    logic [31:0] exp_out;
    logic [31:0] last_out;
    bit last_op_f, last_addr_f, last_acc_f;
    int last_done_cyc = -1;
    bit [7:0] mb [0:4*DEPTH-1];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model's timing and response expectations.
    initial begin
        bit e_busy, e_done;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            e_busy = !exp_fault && cyc >= acc_cyc && cyc < done_at;
            e_done = (cyc == done_at);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            if (done) begin
                last_out = out_d; last_op_f = op_fault; last_addr_f = addr_fault;
                last_acc_f = access_fault; last_done_cyc = cyc;
            end
            if (done && e_done) begin
                chk("op_fault", 32'(op_fault), 32'(exp_op_f));
                chk("addr_fault", 32'(addr_fault), 32'(exp_addr_f));
                chk("access_fault", 32'(access_fault), 32'(exp_acc_f));
                if (exp_chk_out) chk("out", out_d, exp_out);
            end
            if (reset) begin
                chk("rst_out", out_d, 32'd0);
                chk("rst_flags", {29'd0, op_fault, addr_fault, access_fault}, 32'd0);
            end
        end
    end

    // Compute the expected response from the byte memory, drive one request, track it to completion.
    task automatic start_req(input bit w, input bit u, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] d);
        bit of, af, rf, wf;
        int sz;
        logic [31:0] v;
        of = (o == 2'b11);
        af = !of && ((o == 2'b01 && (a % 2) != 0) || (o == 2'b10 && (a % 4) != 0));
        rf = a >= 32'(4 * DEPTH);
        wf = 1'b0;
`ifdef MEM_TARGET_WRITE_PROTECT_EN
        wf = w && ((a / 4) < 32'(RO));
`endif
        sz = (o == 2'b00) ? 1 : (o == 2'b01) ? 2 : 4;
        v = 32'd0;
        if (!(of | af | rf | wf) && !w) begin
            for (int k = 0; k < sz; k++) v |= 32'(mb[a + 32'(k)]) << (8 * k);
            if (!u && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
        end
        exp_fault = of | af | rf | wf;
        exp_op_f = of; exp_addr_f = af; exp_acc_f = exp_fault;
        exp_out = v; exp_chk_out = exp_fault || !w;
        is_write = w; is_unsigned = u; op = o; addr = a; in_d = d;
        available = 1'b1;
        last_done_cyc = -1;
        acc_cyc = cyc + 1;
        done_at = acc_cyc + (exp_fault ? 0 : WC + 1);
    endtask

    task automatic req(input bit w, input bit u, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] d, input int hold);
        int n;
        start_req(w, u, o, a, d);
        n = 0;
        while (cyc < done_at && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (w && !exp_fault)
            for (int k = 0; k < ((o == 2'b00) ? 1 : (o == 2'b01) ? 2 : 4); k++)
                mb[a + 32'(k)] = d[8*k +: 8];
        repeat (hold) @(negedge clk);
        available = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; available = 1'b0; is_write = 1'b0; is_unsigned = 1'b0;
        op = 2'b00; addr = 32'd0; in_d = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out", out_d, 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        chk("reset_flags", {29'd0, op_fault, addr_fault, access_fault}, 32'd0);

        req(1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 0);
        chk("store_latency", 32'(last_done_cyc - acc_cyc), 32'd3);
        req(0, 0, 2'b10, 32'h10, 32'h0, 0);
        chk("load_latency", 32'(last_done_cyc - acc_cyc), 32'd3);
`ifndef MEM_TARGET_WRITE_PROTECT_EN
        chk("lit_word", last_out, 32'hDEADBEEF);
`endif
        req(0, 0, 2'b00, 32'h13, 32'h0, 0);
`ifndef MEM_TARGET_WRITE_PROTECT_EN
        chk("lit_byte_s", last_out, 32'hFFFFFFDE);
`endif
        req(0, 1, 2'b00, 32'h13, 32'h0, 0);
`ifndef MEM_TARGET_WRITE_PROTECT_EN
        chk("lit_byte_u", last_out, 32'h000000DE);
`endif
        req(1, 0, 2'b01, 32'h12, 32'h00001234, 0);
        req(0, 0, 2'b10, 32'h10, 32'h0, 0);
`ifndef MEM_TARGET_WRITE_PROTECT_EN
        chk("lit_half_merge", last_out, 32'h1234BEEF);
`endif
        req(0, 0, 2'b01, 32'h10, 32'h0, 0);
        req(0, 1, 2'b01, 32'h12, 32'h0, 0);

        req(0, 0, 2'b01, 32'h11, 32'h0, 0);
        chk("misalign_latency", 32'(last_done_cyc - acc_cyc), 32'd0);
        chk("misalign_flags", {29'd0, last_op_f, last_addr_f, last_acc_f}, 32'b011);
        chk("misalign_out", last_out, 32'd0);
        req(0, 0, 2'b11, 32'h0, 32'h0, 0);
        chk("badop_flags", {29'd0, last_op_f, last_addr_f, last_acc_f}, 32'b101);
        req(0, 0, 2'b11, 32'h3, 32'h0, 0);
        req(0, 0, 2'b10, 32'h00100000, 32'h0, 4);
        chk("range_flags", {29'd0, last_op_f, last_addr_f, last_acc_f}, 32'b001);
        req(1, 0, 2'b10, 32'h2, 32'h0, 0);

        req(1, 0, 2'b10, 32'h20, 32'hCAFEF00D, 0);
        req(1, 0, 2'b00, 32'h2D, 32'h000000A5, 0);
        req(0, 0, 2'b00, 32'h2D, 32'h0, 0);
        req(0, 1, 2'b00, 32'h2D, 32'h0, 0);

        start_req(1, 0, 2'b10, 32'h20, 32'h11111111);
        repeat (2) @(negedge clk);
        chk("busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        acc_cyc = -1000; done_at = -1000; available = 1'b0;
        #1;
        chk("reset_clears_busy", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        req(0, 0, 2'b10, 32'h20, 32'h0, 0);
`ifndef MEM_TARGET_WRITE_PROTECT_EN
        chk("lit_after_reset", last_out, 32'hCAFEF00D);
`else
        req(1, 0, 2'b10, 32'h20, 32'h55555555, 0);
        chk("wp_flags", {29'd0, last_op_f, last_addr_f, last_acc_f}, 32'b001);
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
